bingo_turn_controller: RTL and testbench

Sequences number picks for one Bingo board. It owns the turn order between the local player (keyboard entry) and the remote board (inter-board link). Local entries are validated against range and against already-called numbers, then each accepted number is issued to the local board datapath. Local picks are also forwarded to the remote board. Sits between the keyboard handler (display_num/enter_pulse), the board marking logic and the inter-board transmitter/receiver.

---
 rtl/bingo_turn_controller_pkg.sv | 27 ++
 rtl/bingo_turn_controller_if.sv | 22 ++
 rtl/bingo_turn_controller_num_check.sv | 21 ++
 rtl/bingo_turn_controller.sv | 128 ++++++++++++
 tb/tb_bingo_turn_controller.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bingo_turn_controller_pkg.sv
// Shared constants, FSM state codes and BCD helpers for the Bingo turn controller.
// Imported by the interface, the number checker and the top level.
package bingo_pkg;

  localparam int MAX_NUM = 25;
  localparam int NUM_W   = 5;

  localparam logic [3:0] S_IDLE          = 4'd0;
  localparam logic [3:0] S_LOCAL_WAIT    = 4'd1;
  localparam logic [3:0] S_LOCAL_CHECK   = 4'd2;
  localparam logic [3:0] S_LOCAL_COMMIT  = 4'd3;
  localparam logic [3:0] S_SEND          = 4'd4;
  localparam logic [3:0] S_REMOTE_WAIT   = 4'd5;
  localparam logic [3:0] S_REMOTE_CHECK  = 4'd6;
  localparam logic [3:0] S_REMOTE_COMMIT = 4'd7;
  localparam logic [3:0] S_DONE          = 4'd8;

  // Only meaningful when both digits are legal; illegal digits are rejected separately.
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
  endfunction

  function automatic logic bcd_bad(input logic [7:0] bcd);
    return (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/bingo_turn_controller_if.sv
// Pick handshake towards the board datapath and send handshake towards the transmitter.
interface bingo_turn_controller_if #(parameter int NUM_W = bingo_pkg::NUM_W);

  logic             pick_valid;
  logic [NUM_W-1:0] pick_num;
  logic             pick_src;
  logic             pick_ready;
  logic             send_valid;
  logic [NUM_W-1:0] send_num;
  logic             send_ack;

  modport master (
    output pick_valid, pick_num, pick_src, send_valid, send_num,
    input  pick_ready, send_ack
  );

  modport slave (
    input  pick_valid, pick_num, pick_src, send_valid, send_num,
    output pick_ready, send_ack
  );

endinterface

// File: rtl/bingo_turn_controller_num_check.sv
// Combinational legality check of a candidate number against range and the called-number mask.
module bingo_num_check #(
  parameter int MAX_NUM = 25
) (
  input  logic [6:0]         val,
  input  logic [MAX_NUM-1:0] used_mask,
  output logic               ok,
  output logic               out_of_range,
  output logic               duplicate
);

  always_comb begin
    out_of_range = (val == 7'd0) || (val > 7'(MAX_NUM));
    duplicate    = 1'b0;
    for (int i = 0; i < MAX_NUM; i++) begin
      if (val == 7'(i + 1)) duplicate = used_mask[i];
    end
    ok = !out_of_range && !duplicate;
  end

endmodule

// File: rtl/bingo_turn_controller.sv
// Turn sequencer for one Bingo board: validates local and remote picks, issues them to the
// board datapath and forwards local picks to the other board.
module bingo_turn_controller
  import bingo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    local_first,
  input  logic [7:0]              display_num,
  input  logic                    enter_pulse,
  input  logic                    remote_valid,
  input  logic [NUM_W-1:0]        remote_num,
  bingo_turn_controller_if.master bus,
  output logic                    clear_entry,
  output logic                    local_err,
  output logic                    remote_err,
  input  logic                    game_over,
  output logic                    my_turn,
  output logic [MAX_NUM-1:0]      used_mask,
  output logic                    done
);

  logic [3:0]         state;
  logic [6:0]         val_q;
  logic               bcd_bad_q;
  logic               chk_ok;
  logic               chk_oor;
  logic               chk_dup;
  logic               local_ok;
  logic               mask_full;
  logic [MAX_NUM-1:0] val_onehot;

  // One checker serves both paths because val_q holds whichever pick is under test.
  bingo_num_check #(.MAX_NUM(MAX_NUM)) u_check (
    .val          (val_q),
    .used_mask    (used_mask),
    .ok           (chk_ok),
    .out_of_range (chk_oor),
    .duplicate    (chk_dup)
  );

  assign local_ok  = !chk_oor && !chk_dup && !bcd_bad_q;
  assign mask_full = &used_mask;

  always_comb begin
    val_onehot = '0;
    for (int i = 0; i < MAX_NUM; i++) begin
      val_onehot[i] = (val_q == 7'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      val_q     <= '0;
      bcd_bad_q <= 1'b0;
      used_mask <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            used_mask <= '0;
            state     <= local_first ? S_LOCAL_WAIT : S_REMOTE_WAIT;
          end
        end
        S_LOCAL_WAIT: begin
          if (game_over) begin
            state <= S_DONE;
          end else if (enter_pulse) begin
            val_q     <= bcd_to_bin(display_num);
            bcd_bad_q <= bcd_bad(display_num);
            state     <= S_LOCAL_CHECK;
          end
        end
        S_LOCAL_CHECK: begin
          if (local_ok) begin
            used_mask <= used_mask | val_onehot;
            state     <= S_LOCAL_COMMIT;
          end else begin
            state <= S_LOCAL_WAIT;
          end
        end
        S_LOCAL_COMMIT: begin
          if (bus.pick_ready) state <= S_SEND;
        end
        // game_over is only honoured once the in-flight send has completed.
        S_SEND: begin
          if (bus.send_ack) state <= (game_over || mask_full) ? S_DONE : S_REMOTE_WAIT;
        end
        S_REMOTE_WAIT: begin
          if (game_over) begin
            state <= S_DONE;
          end else if (remote_valid) begin
            val_q     <= 7'(remote_num);
            bcd_bad_q <= 1'b0;
            state     <= S_REMOTE_CHECK;
          end
        end
        S_REMOTE_CHECK: begin
          if (chk_ok) begin
            used_mask <= used_mask | val_onehot;
            state     <= S_REMOTE_COMMIT;
          end else begin
            state <= S_REMOTE_WAIT;
          end
        end
        S_REMOTE_COMMIT: begin
          if (bus.pick_ready) state <= (game_over || mask_full) ? S_DONE : S_LOCAL_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state directly so an asynchronous reset drops them at once.
  assign bus.pick_valid = (state == S_LOCAL_COMMIT) || (state == S_REMOTE_COMMIT);
  assign bus.pick_num   = bus.pick_valid ? val_q[NUM_W-1:0] : '0;
  assign bus.pick_src   = (state == S_REMOTE_COMMIT);
  assign bus.send_valid = (state == S_SEND);
  assign bus.send_num   = bus.send_valid ? val_q[NUM_W-1:0] : '0;
  assign clear_entry    = (state == S_LOCAL_CHECK);
  assign local_err      = (state == S_LOCAL_CHECK) && !local_ok;
  assign remote_err     = (state == S_REMOTE_CHECK) && (chk_oor || chk_dup);
  assign my_turn        = (state == S_LOCAL_WAIT);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_bingo_turn_controller.sv
// Directed self-checking bench for bingo_turn_controller with hand-computed expectations.
module tb_bingo_turn_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        local_first = 1'b0;
  logic [7:0]  display_num = 8'h00;
  logic        enter_pulse = 1'b0;
  logic        remote_valid = 1'b0;
  logic [4:0]  remote_num = 5'd0;
  logic        clear_entry;
  logic        local_err;
  logic        remote_err;
  logic        game_over = 1'b0;
  logic        my_turn;
  logic [24:0] used_mask;
  logic        done;

  int tests = 0;
  int fails = 0;

  bingo_turn_controller_if bus ();

  bingo_turn_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .local_first  (local_first),
    .display_num  (display_num),
    .enter_pulse  (enter_pulse),
    .remote_valid (remote_valid),
    .remote_num   (remote_num),
    .bus          (bus),
    .clear_entry  (clear_entry),
    .local_err    (local_err),
    .remote_err   (remote_err),
    .game_over    (game_over),
    .my_turn      (my_turn),
    .used_mask    (used_mask),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of pulse inputs, crosses one clock edge, then drops the pulses.
  task automatic applyStimulus(input logic st, input logic lf, input logic [7:0] disp,
                               input logic ent, input logic rv, input logic [4:0] rn);
    start        = st;
    local_first  = lf;
    display_num  = disp;
    enter_pulse  = ent;
    remote_valid = rv;
    remote_num   = rn;
    @(posedge clk);
    #1;
    start        = 1'b0;
    enter_pulse  = 1'b0;
    remote_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] bad_entries [4];

  initial begin
    bad_entries[0] = 8'h07;
    bad_entries[1] = 8'h26;
    bad_entries[2] = 8'h00;
    bad_entries[3] = 8'h1A;
    bus.pick_ready = 1'b0;
    bus.send_ack   = 1'b0;

    rst = 1'b1;
    #12;
    checkOutput("rst_pick_valid", 32'(bus.pick_valid), 32'd0);
    checkOutput("rst_send_valid", 32'(bus.send_valid), 32'd0);
    checkOutput("rst_my_turn",    32'(my_turn),        32'd0);
    checkOutput("rst_done",       32'(done),           32'd0);
    checkOutput("rst_used_mask",  32'(used_mask),      32'd0);
    checkOutput("rst_clear",      32'(clear_entry),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Local first pick of 7, send_ack delayed three cycles.
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0);
    checkOutput("start_my_turn", 32'(my_turn), 32'd1);
    bus.pick_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 5'd0);
    checkOutput("chk7_clear",   32'(clear_entry),    32'd1);
    checkOutput("chk7_err",     32'(local_err),      32'd0);
    checkOutput("chk7_novalid", 32'(bus.pick_valid), 32'd0);
    idleCycles(1);
    checkOutput("pick7_valid", 32'(bus.pick_valid), 32'd1);
    checkOutput("pick7_num",   32'(bus.pick_num),   32'd7);
    checkOutput("pick7_src",   32'(bus.pick_src),   32'd0);
    checkOutput("pick7_mask",  32'(used_mask),      32'h40);
    idleCycles(1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("send7_valid", 32'(bus.send_valid), 32'd1);
      checkOutput("send7_num",   32'(bus.send_num),   32'd7);
      idleCycles(1);
    end
    bus.send_ack = 1'b1;
    idleCycles(1);
    bus.send_ack = 1'b0;
    checkOutput("rw_send_drop", 32'(bus.send_valid), 32'd0);
    checkOutput("rw_my_turn",   32'(my_turn),        32'd0);

    // Remote pick 12.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd12);
    checkOutput("r12_err", 32'(remote_err), 32'd0);
    idleCycles(1);
    checkOutput("r12_valid", 32'(bus.pick_valid), 32'd1);
    checkOutput("r12_num",   32'(bus.pick_num),   32'd12);
    checkOutput("r12_src",   32'(bus.pick_src),   32'd1);
    checkOutput("r12_mask",  32'(used_mask),      32'h840);
    idleCycles(1);
    checkOutput("r12_my_turn", 32'(my_turn), 32'd1);

    // Rejected local entries: duplicate, too large, zero, illegal BCD digit.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, bad_entries[i], 1'b1, 1'b0, 5'd0);
      checkOutput("bad_local_err", 32'(local_err),      32'd1);
      checkOutput("bad_clear",     32'(clear_entry),    32'd1);
      checkOutput("bad_no_pick",   32'(bus.pick_valid), 32'd0);
      idleCycles(1);
      checkOutput("bad_my_turn",   32'(my_turn),        32'd1);
      checkOutput("bad_err_pulse", 32'(local_err),      32'd0);
    end
    checkOutput("bad_mask", 32'(used_mask), 32'h840);

    // Upper boundary 25 accepted, immediate send_ack.
    applyStimulus(1'b0, 1'b0, 8'h25, 1'b1, 1'b0, 5'd0);
    checkOutput("l25_err", 32'(local_err), 32'd0);
    idleCycles(1);
    checkOutput("l25_num", 32'(bus.pick_num), 32'd25);
    idleCycles(1);
    checkOutput("l25_send_num", 32'(bus.send_num), 32'd25);
    bus.send_ack = 1'b1;
    idleCycles(1);
    bus.send_ack = 1'b0;
    checkOutput("l25_mask", 32'(used_mask), 32'h1000840);

    // Remote rejects: duplicate 7 and out-of-range 26; enter_pulse ignored.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd7);
    checkOutput("r7_err", 32'(remote_err), 32'd1);
    idleCycles(1);
    checkOutput("r7_err_pulse", 32'(remote_err),     32'd0);
    checkOutput("r7_no_pick",   32'(bus.pick_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd26);
    checkOutput("r26_err", 32'(remote_err), 32'd1);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 5'd0);
    checkOutput("rw_enter_clear", 32'(clear_entry), 32'd0);
    checkOutput("rw_enter_turn",  32'(my_turn),     32'd0);
    idleCycles(1);
    checkOutput("rw_enter_no_pick", 32'(bus.pick_valid), 32'd0);

    // Valid remote 3.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3);
    idleCycles(1);
    checkOutput("r3_num", 32'(bus.pick_num), 32'd3);
    checkOutput("r3_src", 32'(bus.pick_src), 32'd1);
    idleCycles(1);
    checkOutput("r3_my_turn", 32'(my_turn), 32'd1);

    // Stalled local commit of 9 with game_over rising mid-stall.
    bus.pick_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h09, 1'b1, 1'b0, 5'd0);
    idleCycles(1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", 32'(bus.pick_valid), 32'd1);
      checkOutput("stall_num",   32'(bus.pick_num),   32'd9);
      if (i == 3) game_over = 1'b1;
      idleCycles(1);
    end
    bus.pick_ready = 1'b1;
    idleCycles(1);
    checkOutput("go_send_valid", 32'(bus.send_valid), 32'd1);
    checkOutput("go_send_num",   32'(bus.send_num),   32'd9);
    checkOutput("go_not_done",   32'(done),           32'd0);
    bus.send_ack = 1'b1;
    idleCycles(1);
    bus.send_ack = 1'b0;
    checkOutput("go_done", 32'(done),      32'd1);
    checkOutput("go_mask", 32'(used_mask), 32'h1000944);
    game_over = 1'b0;

    // New game from DONE, then asynchronous reset while send_valid is high.
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0);
    checkOutput("ng_mask",    32'(used_mask), 32'd0);
    checkOutput("ng_my_turn", 32'(my_turn),   32'd1);
    applyStimulus(1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 5'd0);
    idleCycles(2);
    checkOutput("pre_rst_send", 32'(bus.send_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_send_valid", 32'(bus.send_valid), 32'd0);
    checkOutput("arst_send_num",   32'(bus.send_num),   32'd0);
    checkOutput("arst_mask",       32'(used_mask),      32'd0);
    checkOutput("arst_my_turn",    32'(my_turn),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
    checkOutput("clean_my_turn", 32'(my_turn),   32'd0);
    checkOutput("clean_done",    32'(done),      32'd0);
    checkOutput("clean_mask",    32'(used_mask), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd5);
    checkOutput("clean_r5_err", 32'(remote_err), 32'd0);
    idleCycles(1);
    checkOutput("clean_r5_num",  32'(bus.pick_num), 32'd5);
    checkOutput("clean_r5_mask", 32'(used_mask),    32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
